// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - issue-side scoreboard that stalls ID until every operand is forwardable
//
// Tracks results that are not yet forwardable (loads, multi-cycle ops) with one
// countdown per architectural register. An instruction in ID is held until all
// of its sources, and its destination (WAW), have counted down to zero.
//
// Optional build macro: HAZARD_SCOREBOARD_STATS_EN adds a saturating stall-cycle
// counter (o_stall_cycles) with a synchronous clear (i_stats_clear).
//
// Ports:
//   i_clock          pipeline clock, rising edge
//   i_reset          asynchronous active-high reset
//   i_issue_valid    instruction in ID requests issue
//   i_issue_we       instruction writes i_rd
//   i_use_rs/i_use_rt instruction reads i_rs / i_rt
//   i_rs, i_rt, i_rd source A, source B, destination register addresses
//   i_lat            cycles after acceptance until result is forwardable (0 = now)
//   i_kill           squash the instruction accepted in the previous cycle
//   i_stats_clear    (stats build) zero the stall-cycle counter
//   o_stall          issue blocked this cycle
//   o_accept         i_issue_valid & ~o_stall
//   o_pending        per-register "counter nonzero" bit
//   o_busy_count     registered count of nonzero counters
//   o_stall_cycles   (stats build) saturating count of stalled cycles

module hazard_scoreboard #(
  parameter int NB_REG_ADDR = 5,
  parameter int NB_LAT      = 3
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_issue_valid,
  input  logic                          i_issue_we,
  input  logic                          i_use_rs,
  input  logic                          i_use_rt,
  input  logic [NB_REG_ADDR-1:0]        i_rs,
  input  logic [NB_REG_ADDR-1:0]        i_rt,
  input  logic [NB_REG_ADDR-1:0]        i_rd,
  input  logic [NB_LAT-1:0]             i_lat,
  input  logic                          i_kill,
`ifdef HAZARD_SCOREBOARD_STATS_EN
  input  logic                          i_stats_clear,
  output logic [31:0]                   o_stall_cycles,
`endif
  output logic                          o_stall,
  output logic                          o_accept,
  output logic [(1<<NB_REG_ADDR)-1:0]   o_pending,
  output logic [NB_REG_ADDR:0]          o_busy_count
);

  localparam int NREG   = 1 << NB_REG_ADDR;
  localparam int NB_CNT = NB_REG_ADDR + 1;

  logic [NB_LAT-1:0]      cnt     [NREG];
  logic [NB_LAT-1:0]      cnt_nxt [NREG];
  logic [NB_CNT-1:0]      busy_nxt;

  // Kill tracking: destination of the last recording acceptance, valid for one cycle.
  logic [NB_REG_ADDR-1:0] last_rd;
  logic                   last_valid;

  logic hz_rs;
  logic hz_rt;
  logic hz_rd;
  logic record;
  logic kill_hit;

  // Hazard detection is purely from the current counters. r0 is excluded
  // explicitly even though cnt[0] is held at zero.
  always_comb begin
    hz_rs    = i_use_rs & (i_rs != '0) & (cnt[i_rs] != '0);
    hz_rt    = i_use_rt & (i_rt != '0) & (cnt[i_rt] != '0);
    hz_rd    = i_issue_we & (i_rd != '0) & (cnt[i_rd] != '0);
    o_stall  = i_issue_valid & (hz_rs | hz_rt | hz_rd);
    o_accept = i_issue_valid & ~o_stall;
    record   = o_accept & i_issue_we & (i_rd != '0) & (i_lat != '0);
    kill_hit = i_kill & last_valid;
  end

  // Next-state per register: decrement, then a new recording, then a kill.
  // Later assignments win, so a kill overrides an acceptance to the same rd.
  always_comb begin
    busy_nxt = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_nxt[r] = (cnt[r] != '0) ? (cnt[r] - NB_LAT'(1)) : '0;
      if (record && (i_rd == NB_REG_ADDR'(r))) begin
        cnt_nxt[r] = i_lat;
      end
      if (kill_hit && (last_rd == NB_REG_ADDR'(r))) begin
        cnt_nxt[r] = '0;
      end
      if (r == 0) begin
        cnt_nxt[r] = '0;
      end
      busy_nxt = busy_nxt + NB_CNT'(cnt_nxt[r] != '0);
    end
  end

  always_comb begin
    o_pending = '0;
    for (int r = 0; r < NREG; r++) begin
      o_pending[r] = (cnt[r] != '0);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
      last_rd      <= '0;
      last_valid   <= 1'b0;
      o_busy_count <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
      last_rd      <= i_rd;
      last_valid   <= record;
      o_busy_count <= busy_nxt;
    end
  end

`ifdef HAZARD_SCOREBOARD_STATS_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_stall_cycles <= '0;
    end else if (i_stats_clear) begin
      o_stall_cycles <= '0;
    end else if (o_stall && (o_stall_cycles != 32'hFFFF_FFFF)) begin
      o_stall_cycles <= o_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking scoreboard bench for hazard_scoreboard

module tb_hazard_scoreboard;

  localparam int NA = 5;
  localparam int NL = 3;
  localparam int NR = 1 << NA;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid, issue_we, use_rs, use_rt, kill;
  logic [NA-1:0] rs, rt, rd;
  logic [NL-1:0] lat;
  logic          stall, accept;
  logic [NR-1:0] pending;
  logic [NA:0]   busy_count;
`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic          stats_clear;
  logic [31:0]   stall_cycles;
`endif

  hazard_scoreboard #(.NB_REG_ADDR(NA), .NB_LAT(NL)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_issue_valid(issue_valid),
    .i_issue_we   (issue_we),
    .i_use_rs     (use_rs),
    .i_use_rt     (use_rt),
    .i_rs         (rs),
    .i_rt         (rt),
    .i_rd         (rd),
    .i_lat        (lat),
    .i_kill       (kill),
`ifdef HAZARD_SCOREBOARD_STATS_EN
    .i_stats_clear(stats_clear),
    .o_stall_cycles(stall_cycles),
`endif
    .o_stall      (stall),
    .o_accept     (accept),
    .o_pending    (pending),
    .o_busy_count (busy_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          stall;
    logic          accept;
    logic [NR-1:0] pending;
    logic [NA:0]   busy;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state
  int   mcnt[NR];
  int   mlast_rd;
  bit   mlast_v;
  int   mstalls;

  task automatic model_reset();
    for (int r = 0; r < NR; r++) mcnt[r] = 0;
    mlast_rd = 0;
    mlast_v  = 1'b0;
    mstalls  = 0;
  endtask

  // Applies one cycle of stimulus, predicts the outcome and queues both sides.
  task automatic drive_cycle(input bit v, input bit we, input bit urs, input bit urt,
                             input int a_rs, input int a_rt, input int a_rd,
                             input int a_lat, input bit a_kill);
    rec_t e, o;
    bit   rec;
    issue_valid = v;   issue_we = we;   use_rs = urs;   use_rt = urt;
    rs = NA'(a_rs);    rt = NA'(a_rt);  rd = NA'(a_rd); lat = NL'(a_lat);
    kill = a_kill;
    #1;
    o.stall  = stall;
    o.accept = accept;
    e.stall  = v && ((urs && a_rs != 0 && mcnt[a_rs] != 0) ||
                     (urt && a_rt != 0 && mcnt[a_rt] != 0) ||
                     (we && a_rd != 0 && mcnt[a_rd] != 0));
    e.accept = v && !e.stall;
    if (e.stall) mstalls++;
    for (int r = 0; r < NR; r++) if (mcnt[r] > 0) mcnt[r]--;
    rec = e.accept && we && a_rd != 0 && a_lat != 0;
    if (rec) mcnt[a_rd] = a_lat;
    if (a_kill && mlast_v) mcnt[mlast_rd] = 0;
    mlast_rd = a_rd;
    mlast_v  = rec;
    e.pending = '0;
    e.busy    = '0;
    for (int r = 0; r < NR; r++) begin
      if (mcnt[r] != 0) begin
        e.pending[r] = 1'b1;
        e.busy       = e.busy + 1'b1;
      end
    end
    @(posedge clk);
    #1;
    o.pending = pending;
    o.busy    = busy_count;
    exp_q.push_back(e);
    obs_q.push_back(o);
  endtask

  task automatic idle(input int n, input bit a_kill);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, a_kill);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    issue_valid = 1'b1; issue_we = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
    rs = 5'd1; rt = 5'd2; rd = 5'd3; lat = 3'd7; kill = 1'b1;
`ifdef HAZARD_SCOREBOARD_STATS_EN
    stats_clear = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (pending !== '0 || busy_count !== '0 || stall !== 1'b0 || accept !== 1'b1) begin
      miscompares++;
      $display("FAIL reset: got pend=%h busy=%0d stall=%b acc=%b, want pend=0 busy=0 stall=0 acc=1",
               pending, busy_count, stall, accept);
    end
    rst = 1'b0;
    idle(1, 0);
    while (exp_q.size() != 0) begin
      rec_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset_idle: got stall=%b acc=%b pend=%h busy=%0d, want stall=%b acc=%b pend=%h busy=%0d",
                 o.stall, o.accept, o.pending, o.busy, e.stall, e.accept, e.pending, e.busy);
      end
    end
  endtask

  task automatic test_load_use();
    drive_cycle(1, 1, 0, 0, 0, 0, 5, 2, 0);
    for (int i = 0; i < 3; i++) drive_cycle(1, 0, 1, 0, 5, 0, 0, 0, 0);
    while (exp_q.size() != 0) begin
      rec_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL load_use: got stall=%b acc=%b pend=%h busy=%0d, want stall=%b acc=%b pend=%h busy=%0d",
                 o.stall, o.accept, o.pending, o.busy, e.stall, e.accept, e.pending, e.busy);
      end
    end
  endtask

  task automatic test_lat0_r0();
    drive_cycle(1, 1, 0, 0, 0, 0, 7, 0, 0);
    drive_cycle(1, 0, 1, 0, 7, 0, 0, 0, 0);
    drive_cycle(1, 1, 0, 0, 0, 0, 0, 3, 0);
    drive_cycle(1, 1, 1, 1, 0, 0, 0, 3, 0);
    vectors++;
    if (pending !== '0 || busy_count !== '0) begin
      miscompares++;
      $display("FAIL r0_untracked: got pend=%h busy=%0d, want pend=0 busy=0", pending, busy_count);
    end
    while (exp_q.size() != 0) begin
      rec_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL lat0_r0: got stall=%b acc=%b pend=%h busy=%0d, want stall=%b acc=%b pend=%h busy=%0d",
                 o.stall, o.accept, o.pending, o.busy, e.stall, e.accept, e.pending, e.busy);
      end
    end
  endtask

  task automatic test_waw_rt();
    drive_cycle(1, 1, 0, 0, 0, 0, 9, 4, 0);
    for (int i = 0; i < 5; i++) drive_cycle(1, 1, 0, 0, 0, 0, 9, 1, 0);
    for (int i = 0; i < 3; i++) drive_cycle(1, 0, 0, 1, 0, 9, 0, 0, 0);
    while (exp_q.size() != 0) begin
      rec_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL waw_rt: got stall=%b acc=%b pend=%h busy=%0d, want stall=%b acc=%b pend=%h busy=%0d",
                 o.stall, o.accept, o.pending, o.busy, e.stall, e.accept, e.pending, e.busy);
      end
    end
  endtask

  task automatic test_kill();
    drive_cycle(1, 1, 0, 0, 0, 0, 3, 5, 0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive_cycle(1, 0, 1, 0, 3, 0, 0, 0, 0);
    drive_cycle(1, 1, 0, 0, 0, 0, 6, 4, 0);
    idle(1, 0);
    idle(1, 1);
    drive_cycle(1, 1, 0, 0, 0, 0, 13, 3, 0);
    drive_cycle(1, 1, 0, 0, 0, 0, 14, 2, 1);
    idle(4, 0);
    while (exp_q.size() != 0) begin
      rec_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL kill: got stall=%b acc=%b pend=%h busy=%0d, want stall=%b acc=%b pend=%h busy=%0d",
                 o.stall, o.accept, o.pending, o.busy, e.stall, e.accept, e.pending, e.busy);
      end
    end
  endtask

  task automatic test_multi_pending();
    drive_cycle(1, 1, 0, 0, 0, 0, 1, 3, 0);
    drive_cycle(1, 1, 0, 0, 0, 0, 2, 2, 0);
    drive_cycle(1, 1, 0, 0, 0, 0, 4, 1, 0);
    idle(3, 0);
    while (exp_q.size() != 0) begin
      rec_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL multi_pending: got stall=%b acc=%b pend=%h busy=%0d, want stall=%b acc=%b pend=%h busy=%0d",
                 o.stall, o.accept, o.pending, o.busy, e.stall, e.accept, e.pending, e.busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 4) == 0);
    end
    while (exp_q.size() != 0) begin
      rec_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL back_to_back: got stall=%b acc=%b pend=%h busy=%0d, want stall=%b acc=%b pend=%h busy=%0d",
                 o.stall, o.accept, o.pending, o.busy, e.stall, e.accept, e.pending, e.busy);
      end
    end
  endtask

`ifdef HAZARD_SCOREBOARD_STATS_EN
  task automatic test_stats();
    stats_clear = 1'b1;
    idle(1, 0);
    stats_clear = 1'b0;
    mstalls = 0;
    vectors++;
    if (stall_cycles !== 32'd0) begin
      miscompares++;
      $display("FAIL stats_clear: got %0d want 0", stall_cycles);
    end
    drive_cycle(1, 1, 0, 0, 0, 0, 20, 6, 0);
    for (int i = 0; i < 7; i++) drive_cycle(1, 0, 0, 1, 0, 20, 0, 0, 0);
    vectors++;
    if (stall_cycles !== 32'(mstalls)) begin
      miscompares++;
      $display("FAIL stats_count: got %0d want %0d", stall_cycles, mstalls);
    end
    exp_q.delete();
    obs_q.delete();
  endtask
`endif

  task automatic test_mid_reset();
    drive_cycle(1, 1, 0, 0, 0, 0, 10, 7, 0);
    drive_cycle(1, 1, 0, 0, 0, 0, 11, 7, 0);
    drive_cycle(1, 1, 0, 0, 0, 0, 12, 7, 0);
    issue_valid = 1'b1; issue_we = 1'b0; use_rs = 1'b1; use_rt = 1'b0; rs = 5'd10;
    kill = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (stall !== 1'b1 || busy_count !== 6'd3) begin
      miscompares++;
      $display("FAIL pre_reset: got stall=%b busy=%0d, want stall=1 busy=3", stall, busy_count);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (pending !== '0 || busy_count !== '0 || stall !== 1'b0 || accept !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset: got pend=%h busy=%0d stall=%b acc=%b, want pend=0 busy=0 stall=0 acc=1",
               pending, busy_count, stall, accept);
    end
`ifdef HAZARD_SCOREBOARD_STATS_EN
    vectors++;
    if (stall_cycles !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_reset_stats: got %0d want 0", stall_cycles);
    end
`endif
    #1;
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    obs_q.delete();
    @(posedge clk);
    #1;
    idle(1, 1);
    drive_cycle(1, 0, 1, 1, 10, 11, 0, 0, 0);
    while (exp_q.size() != 0) begin
      rec_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL post_reset: got stall=%b acc=%b pend=%h busy=%0d, want stall=%b acc=%b pend=%h busy=%0d",
                 o.stall, o.accept, o.pending, o.busy, e.stall, e.accept, e.pending, e.busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_lat0_r0();
    test_waw_rt();
    test_kill();
    test_multi_pending();
    test_back_to_back();
`ifdef HAZARD_SCOREBOARD_STATS_EN
    test_stats();
`endif
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
